// File: rtl/f_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface f_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/f_fetch.sv
// Fetch stage: owns F_PC, issues imem requests and loads the F/D register.
// Optional fetch address-error detection is enabled by defining F_ADEL_EN.
module f_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_MAX   = 32'h0000_6ffc
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] NPC,
    input  logic        stall,
    f_fetch_if.master   imem,
    output logic [31:0] F_PC,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic        D_valid,
    output logic        D_exc,
    output logic        fetch_busy
);

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] hold_instr;
    logic        hold_exc;
    logic        addr_err;
    logic [31:0] fetch_word;
    logic        xfer;
    logic        capture;
    logic [31:0] xfer_instr;
    logic        xfer_exc;

`ifdef F_ADEL_EN
    assign addr_err = (F_PC[1:0] != 2'b00) || (F_PC < PC_RESET) || (F_PC > PC_MAX);
`else
    assign addr_err = 1'b0;
`endif

    // A faulting PC completes without memory, delivering a nop word.
    assign fetch_word = addr_err ? '0 : imem.imem_rdata;

    always_comb begin
        state_nxt      = state;
        imem.imem_req  = 1'b0;
        imem.imem_addr = F_PC;
        fetch_busy     = 1'b0;
        xfer           = 1'b0;
        capture        = 1'b0;
        xfer_instr     = hold_instr;
        xfer_exc       = hold_exc;
        case (state)
            FETCH: begin
                imem.imem_req = !addr_err;
                fetch_busy    = !addr_err && !imem.imem_ack;
                if (addr_err || imem.imem_ack) begin
                    if (stall) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        xfer       = 1'b1;
                        xfer_instr = fetch_word;
                        xfer_exc   = addr_err;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    xfer      = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            F_PC       <= PC_RESET;
            D_Instr    <= '0;
            D_PC       <= '0;
            D_valid    <= 1'b0;
            D_exc      <= 1'b0;
            hold_instr <= '0;
            hold_exc   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_instr <= fetch_word;
                hold_exc   <= addr_err;
            end
            if (xfer) begin
                D_Instr <= xfer_instr;
                D_PC    <= F_PC;
                D_valid <= 1'b1;
                D_exc   <= xfer_exc;
                F_PC    <= NPC;
            end
        end
    end

endmodule

// File: tb/tb_f_fetch.sv
// Scoreboard bench for f_fetch: directed fetch/stall/reset vectors, D-register updates checked by a monitor.
module tb_f_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] NPC;
    logic        stall;
    logic [31:0] F_PC;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic        D_valid;
    logic        D_exc;
    logic        fetch_busy;

    f_fetch_if imem ();

    f_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .NPC        (NPC),
        .stall      (stall),
        .imem       (imem.master),
        .F_PC       (F_PC),
        .D_Instr    (D_Instr),
        .D_PC       (D_PC),
        .D_valid    (D_valid),
        .D_exc      (D_exc),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        exc;
        logic [31:0] pc;
        logic [31:0] instr;
    } dreg_t;

    dreg_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic exp_d(input logic [31:0] pc, input logic [31:0] instr, input logic exc);
        sb.push_back({1'b1, exc, pc, instr});
    endtask

    // One cycle: drive on the falling edge, check combinational/registered outputs before the rising edge.
    task automatic cyc(input string tag, input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic [31:0] npc, input logic e_req, input logic e_busy, input logic [31:0] e_pc);
        @(negedge clk);
        imem.imem_ack   = ack;
        imem.imem_rdata = rdata;
        stall           = stl;
        NPC             = npc;
        #1;
        chk32({tag, ".f_pc"}, F_PC, e_pc);
        chk1({tag, ".imem_req"}, imem.imem_req, e_req);
        chk1({tag, ".fetch_busy"}, fetch_busy, e_busy);
        if (e_req) chk32({tag, ".imem_addr"}, imem.imem_addr, e_pc);
    endtask

    initial begin : monitor
        dreg_t prev;
        dreg_t cur;
        dreg_t e;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = {D_valid, D_exc, D_PC, D_Instr};
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL d_unexpected: got v%b x%b pc %h instr %h expected no update",
                             cur.valid, cur.exc, cur.pc, cur.instr);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL d_reg: got v%b x%b pc %h instr %h expected v%b x%b pc %h instr %h",
                                 cur.valid, cur.exc, cur.pc, cur.instr, e.valid, e.exc, e.pc, e.instr);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish expected finish within 100000");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n         = 1'b1;
        stall           = 1'b0;
        NPC             = '0;
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;
        #1 reset_n = 1'b0;
        #2;
        chk32("rst.f_pc", F_PC, 32'h0000_3000);
        chk1("rst.d_valid", D_valid, 1'b0);
        chk32("rst.d_pc", D_PC, 32'h0);
        chk32("rst.d_instr", D_Instr, 32'h0);
        chk1("rst.d_exc", D_exc, 1'b0);
        chk1("rst.imem_req", imem.imem_req, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // zero-wait memory, sequential PCs
        exp_d(32'h3000, 32'hA000_0001, 1'b0);
        cyc("zw0", 1'b1, 32'hA000_0001, 1'b0, 32'h3004, 1'b1, 1'b0, 32'h3000);
        exp_d(32'h3004, 32'hA000_0002, 1'b0);
        cyc("zw1", 1'b1, 32'hA000_0002, 1'b0, 32'h3008, 1'b1, 1'b0, 32'h3004);
        exp_d(32'h3008, 32'hA000_0003, 1'b0);
        cyc("zw2", 1'b1, 32'hA000_0003, 1'b0, 32'h300c, 1'b1, 1'b0, 32'h3008);

        // three-cycle memory latency
        cyc("lat0", 1'b0, 32'h0, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h300c);
        cyc("lat1", 1'b0, 32'h0, 1'b0, 32'h3010, 1'b1, 1'b1, 32'h300c);
        exp_d(32'h300c, 32'hB000_0001, 1'b0);
        cyc("lat2", 1'b1, 32'hB000_0001, 1'b0, 32'h3010, 1'b1, 1'b0, 32'h300c);

        // ack coincident with stall, held two more cycles; stray ack in HOLD is ignored
        cyc("hold0", 1'b1, 32'h1234_5678, 1'b1, 32'h3014, 1'b1, 1'b0, 32'h3010);
        cyc("hold1", 1'b0, 32'h0, 1'b1, 32'h3014, 1'b0, 1'b0, 32'h3010);
        cyc("hold2", 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h3014, 1'b0, 1'b0, 32'h3010);
        exp_d(32'h3010, 32'h1234_5678, 1'b0);
        cyc("hold3", 1'b0, 32'h0, 1'b0, 32'h3100, 1'b0, 1'b0, 32'h3010);

        // branch target taken at the previous transfer
        exp_d(32'h3100, 32'hC000_0001, 1'b0);
        cyc("br", 1'b1, 32'hC000_0001, 1'b0, 32'h3104, 1'b1, 1'b0, 32'h3100);

        // stall without ack has no effect
        cyc("sw0", 1'b0, 32'h0, 1'b1, 32'h3108, 1'b1, 1'b1, 32'h3104);
        cyc("sw1", 1'b0, 32'h0, 1'b0, 32'h3108, 1'b1, 1'b1, 32'h3104);
        exp_d(32'h3104, 32'hC000_0002, 1'b0);
        cyc("sw2", 1'b1, 32'hC000_0002, 1'b0, 32'h3108, 1'b1, 1'b0, 32'h3104);

        // reset during a pending fetch; ack while in reset must not load D
        cyc("rp0", 1'b0, 32'h0, 1'b0, 32'h310c, 1'b1, 1'b1, 32'h3108);
        sb.push_back('0);
        @(negedge clk);
        reset_n         = 1'b0;
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = 32'hBAD0_BAD0;
        #1;
        chk32("rp.f_pc", F_PC, 32'h3000);
        chk1("rp.d_valid", D_valid, 1'b0);
        chk32("rp.imem_addr", imem.imem_addr, 32'h3000);
        @(negedge clk);
        chk32("rp.d_instr", D_Instr, 32'h0);
        imem.imem_ack = 1'b0;
        reset_n       = 1'b1;
        cyc("rs0", 1'b0, 32'h0, 1'b0, 32'h3004, 1'b1, 1'b1, 32'h3000);
        exp_d(32'h3000, 32'hD000_0001, 1'b0);
        cyc("rs1", 1'b1, 32'hD000_0001, 1'b0, 32'h3004, 1'b1, 1'b0, 32'h3000);

`ifdef F_ADEL_EN
        // misaligned NPC produces a nop with the exception flag, then a clean fetch clears it
        exp_d(32'h3004, 32'hE000_0001, 1'b0);
        cyc("ad0", 1'b1, 32'hE000_0001, 1'b0, 32'h3002, 1'b1, 1'b0, 32'h3004);
        exp_d(32'h3002, 32'h0, 1'b1);
        cyc("ad1", 1'b0, 32'h0, 1'b0, 32'h3008, 1'b0, 1'b0, 32'h3002);
        exp_d(32'h3008, 32'hE000_0002, 1'b0);
        cyc("ad2", 1'b1, 32'hE000_0002, 1'b0, 32'h300c, 1'b1, 1'b0, 32'h3008);
`endif

        @(negedge clk);
        imem.imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk32("sb_drain", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f_fetch.md
# f_fetch

Fetch-stage front end of the five-stage pipeline. Holds the fetch PC `F_PC`, issues instruction-memory requests over a req/ack handshake, and loads the F/D pipeline register (`D_Instr`, `D_PC`). It consumes the next-PC value produced by the D-stage next-PC logic, which in turn reads `F_PC` from this block. It stalls the pipeline while a fetch is outstanding.

## Interface
- `PC_RESET`, default `32'h0000_3000`: value loaded into `F_PC` on reset.
- `PC_MAX`, default `32'h0000_6ffc`: highest legal instruction address; used only under `F_ADEL_EN`.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `NPC` in 32: next PC from D stage, valid every cycle.
- `stall` in 1: hazard-unit stall; freezes `F_PC` and the D register.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to `F_PC`.
- `imem_ack` in 1: memory completes the request this cycle.
- `imem_rdata` in 32: instruction word, valid when `imem_ack`.
- `F_PC` out 32: current fetch PC.
- `D_Instr` out 32: D-stage instruction.
- `D_PC` out 32: D-stage PC.
- `D_valid` out 1: D register holds a real fetched instruction.
- `D_exc` out 1: D instruction carries a fetch address error. Tied 0 without `F_ADEL_EN`.
- `fetch_busy` out 1: fetch outstanding. The hazard unit ORs this into the pipeline stall.

## Operation
- Reset (async, `reset_n`=0):
  - `F_PC`=`PC_RESET`; `D_Instr`=0; `D_PC`=0; `D_valid`=0; `D_exc`=0.
  - Buffer cleared; state=FETCH.
- State FETCH:
  - `imem_req`=1, `imem_addr`=`F_PC`.
  - `fetch_busy` = `!imem_ack`, a combinational path from `imem_ack`.
  - On `imem_ack` && !`stall`: `D_Instr`←`imem_rdata`, `D_PC`←`F_PC`, `D_valid`←1, `F_PC`←`NPC`; stay in FETCH.
  - On `imem_ack` && `stall`: buffer←`imem_rdata`; go to HOLD; `F_PC` and the D register are unchanged.
  - No `imem_ack`: all registers hold, independent of `stall`.
- State HOLD:
  - `imem_req`=0, `fetch_busy`=0.
  - While `stall`=1: hold everything.
  - When `stall`=0: `D_Instr`←buffer, `D_PC`←`F_PC`, `D_valid`←1, `F_PC`←`NPC`; go to FETCH.
- The D register never changes except on the transfer events above. No bubbles are inserted by this block.
- `NPC` is sampled only on transfer edges. `NPC`=`F_PC`+4 arithmetic is modulo 2^32; no wrap detection.
- Memory is expected to accept `imem_addr` changes only after ack. This block never changes `imem_addr` while `imem_req`=1 and ack is pending.

## Timing
- With zero-wait memory (ack in the same cycle as req) and no stall: one instruction per cycle. `D_Instr` appears 1 edge after `F_PC` presents its address.
- With N-cycle memory latency: `fetch_busy` is high for N−1 cycles, and the transfer happens on the edge where ack=1.
- `stall` and `imem_ack` high in the same cycle: HOLD path; the instruction is never lost or refetched.
- Reset mid-fetch or in HOLD: state and buffer are discarded immediately; the outstanding ack is ignored because the state is forced to FETCH with a new request at `PC_RESET`.
- `D_valid` first rises on the first transfer edge after reset release.

## Configuration
- `F_ADEL_EN` defined: in FETCH, if `F_PC[1:0]`≠0, or `F_PC`<`PC_RESET`, or `F_PC`>`PC_MAX`:
  - `imem_req`=0 and `fetch_busy`=0.
  - The transfer proceeds as if acked with `D_Instr`←0 (nop) and `D_exc`←1.
  - `stall` rules are identical to a normal transfer.
  - Any normal transfer sets `D_exc`←0.
- `F_ADEL_EN` undefined: no checks; `D_exc` is constant 0; every PC issues a request.

## Test plan
- Reset release, zero-wait memory, `NPC`=`F_PC`+4 → `F_PC` sequence `0x3000`, `0x3004`, `0x3008` on successive edges; `D_PC` lags by one edge; `D_valid`=1 from the first edge.
- Memory latency 3 at `F_PC`=`0x3000` → `fetch_busy`=1 for 2 cycles, `imem_addr` held at `0x3000`, `D_Instr`=`imem_rdata` on the third edge.
- Ack coincident with `stall`=1 held for 2 cycles, rdata=`0x1234_5678` → `imem_req`=0 during HOLD; `D_Instr`=`0x1234_5678` on the edge after `stall` falls; exactly one request issued.
- `NPC`=`0x3100` (branch taken) at a transfer edge → next `imem_addr`=`0x3100`.
- `reset_n` pulsed low during a pending fetch at `0x3010` → `F_PC`=`0x3000` immediately; `D_valid`=0; a late ack is not captured.
- `F_ADEL_EN`, `NPC`=`0x3002` → next cycle `imem_req`=0; following edge gives `D_exc`=1, `D_Instr`=0, `D_PC`=`0x3002`.
